// File: rtl/button_press_gen.sv
// Emulates a bouncing active-low push button: one short or long press per start,
// with configurable contact bounce on both edges and a released quiet gap afterwards.
module button_press_gen #(
   parameter int unsigned MAX        = 50_000_000,
   parameter int unsigned SHORT_CYC  = MAX / 4,
   parameter int unsigned LONG_CYC   = 2 * MAX,
   parameter int unsigned GAP_CYC    = MAX / 10,
   parameter int unsigned BOUNCE_CYC = 1000,
   parameter int unsigned BOUNCE_N   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] kind,
   input  logic       abort,
   output logic       button,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT,
      GAP
   } state_t;

   localparam logic [31:0] BOUNCE_LAST = 32'(BOUNCE_CYC) - 32'd1;
   localparam logic [31:0] TOGGLE_LAST = 32'(BOUNCE_N) - 32'd1;
   localparam logic [31:0] SHORT_LAST  = 32'(SHORT_CYC) - 32'd1;
   localparam logic [31:0] LONG_LAST   = 32'(LONG_CYC) - 32'd1;
   localparam logic [31:0] GAP_LAST    = 32'(GAP_CYC) - 32'd1;

   state_t      state;
   logic [31:0] count;
   logic [31:0] toggles;
   logic [1:0]  kind_q;
   logic [31:0] hold_last;

   assign hold_last = (kind_q == 2'd2) ? LONG_LAST : SHORT_LAST;

   // NOTE: every register below is assigned with <= so all of them update from
   // the same pre-edge values; blocking writes here would create ordering races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         toggles <= '0;
         kind_q  <= '0;
         button  <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         // Abort outranks every in-flight transition, including the final gap cycle.
         if (state != IDLE && abort) begin
            state   <= IDLE;
            count   <= '0;
            toggles <= '0;
            button  <= 1'b1;
            busy    <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !done) begin
                     if (kind == 2'd1 || kind == 2'd2) begin
                        kind_q  <= kind;
                        busy    <= 1'b1;
                        button  <= 1'b0;
                        count   <= '0;
                        toggles <= '0;
                        state   <= (BOUNCE_N == 0) ? HOLD : BOUNCE_IN;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end

               BOUNCE_IN: begin
                  if (count == BOUNCE_LAST) begin
                     button <= ~button;
                     count  <= '0;
                     if (toggles == TOGGLE_LAST) begin
                        toggles <= '0;
                        state   <= HOLD;
                     end else begin
                        toggles <= toggles + 32'd1;
                     end
                  end else begin
                     count <= count + 32'd1;
                  end
               end

               HOLD: begin
                  if (count == hold_last) begin
                     button <= 1'b1;
                     count  <= '0;
                     state  <= (BOUNCE_N == 0) ? GAP : BOUNCE_OUT;
                  end else begin
                     count <= count + 32'd1;
                  end
               end

               BOUNCE_OUT: begin
                  if (count == BOUNCE_LAST) begin
                     button <= ~button;
                     count  <= '0;
                     if (toggles == TOGGLE_LAST) begin
                        toggles <= '0;
                        state   <= GAP;
                     end else begin
                        toggles <= toggles + 32'd1;
                     end
                  end else begin
                     count <= count + 32'd1;
                  end
               end

               GAP: begin
                  if (count == GAP_LAST) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     count <= '0;
                     state <= IDLE;
                  end else begin
                     count <= count + 32'd1;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_button_press_gen.sv
// Self-checking bench for button_press_gen: one instance with two bounce toggles per
// edge, one without bounce, compared against a waveform model built from press rules.
module tb_button_press_gen;

   localparam int P_MAX   = 100;
   localparam int P_SHORT = 25;
   localparam int P_LONG  = 200;
   localparam int P_GAP   = 10;
   localparam int P_BCYC  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sel = 1'b0;          // 0 observes/drives the bouncing instance, 1 the bounce-free one
   logic       start_drv = 1'b0;
   logic [1:0] kind_drv = 2'd0;
   logic       abort_drv = 1'b0;
   bit         nz_on = 1'b0;
   logic       start_nz = 1'b0;
   logic [1:0] kind_nz = 2'd0;

   logic       start_w, start2, start0, abort2, abort0;
   logic [1:0] kind_w;
   logic       button2, busy2, done2, err2;
   logic       button0, busy0, done0, err0;
   logic       o_button, o_busy, o_done, o_err;

   assign start_w = start_drv | (nz_on & start_nz);
   assign kind_w  = nz_on ? kind_nz : kind_drv;
   assign start2  = start_w & ~sel;
   assign start0  = start_w & sel;
   assign abort2  = abort_drv & ~sel;
   assign abort0  = abort_drv & sel;
   assign o_button = sel ? button0 : button2;
   assign o_busy   = sel ? busy0 : busy2;
   assign o_done   = sel ? done0 : done2;
   assign o_err    = sel ? err0 : err2;

   button_press_gen #(
      .MAX(P_MAX), .SHORT_CYC(P_SHORT), .LONG_CYC(P_LONG), .GAP_CYC(P_GAP),
      .BOUNCE_CYC(P_BCYC), .BOUNCE_N(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start2), .kind(kind_w), .abort(abort2),
      .button(button2), .busy(busy2), .done(done2), .err(err2)
   );

   button_press_gen #(
      .MAX(P_MAX), .SHORT_CYC(P_SHORT), .LONG_CYC(P_LONG), .GAP_CYC(P_GAP),
      .BOUNCE_CYC(P_BCYC), .BOUNCE_N(0)
   ) dut0 (
      .clk(clk), .reset(reset), .start(start0), .kind(kind_w), .abort(abort0),
      .button(button0), .busy(busy0), .done(done0), .err(err0)
   );

   always #5 clk = ~clk;

   // Random start/kind chatter while a press is in flight; it must never be accepted.
   always @(posedge clk) begin
      #1;
      if (nz_on) begin
         start_nz = 1'($urandom_range(0, 1));
         kind_nz  = 2'($urandom_range(0, 3));
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   bit exp_btn[$];
   bit obs_btn[$];
   int obs_busy;
   bit obs_done, obs_err, obs_done_busy, obs_done_btn;

   // Expected button level per busy cycle, built from the press description.
   function automatic void build_expected(input int k, input int nb);
      int hold;
      hold = (k == 2) ? P_LONG : P_SHORT;
      exp_btn.delete();
      for (int i = 0; i < nb; i++)
         for (int c = 0; c < P_BCYC; c++) exp_btn.push_back((i % 2) == 1);
      for (int c = 0; c < hold; c++) exp_btn.push_back(1'b0);
      for (int i = 0; i < nb; i++)
         for (int c = 0; c < P_BCYC; c++) exp_btn.push_back((i % 2) == 0);
      for (int c = 0; c < P_GAP; c++) exp_btn.push_back(1'b1);
   endfunction

   function automatic int first_diff();
      int n;
      n = (obs_btn.size() < exp_btn.size()) ? obs_btn.size() : exp_btn.size();
      for (int i = 0; i < n; i++)
         if (obs_btn[i] != exp_btn[i]) return i;
      if (obs_btn.size() != exp_btn.size()) return n;
      return -1;
   endfunction

   task automatic issue(input logic [1:0] k);
      @(posedge clk); #1;
      start_drv = 1'b1;
      kind_drv  = k;
      @(posedge clk); #1;
      start_drv = 1'b0;
   endtask

   // Records button per busy cycle until done appears, busy drops, or the budget runs out.
   task automatic capture(input int budget);
      obs_btn.delete();
      obs_busy = 0; obs_done = 0; obs_err = 0; obs_done_busy = 1'b1; obs_done_btn = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (o_done === 1'b1) begin
            obs_done = 1; obs_done_busy = o_busy; obs_done_btn = o_button;
            return;
         end
         if (o_err === 1'b1) obs_err = 1;
         if (o_busy !== 1'b1) return;
         obs_btn.push_back(o_button);
         obs_busy++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      n_checks++; if ({button2, busy2, done2, err2} !== 4'b1000)
         $display("FAIL reset_async_b2: outputs {button,busy,done,err}=%b, expected 1000", {button2, busy2, done2, err2}); else n_pass++;
      n_checks++; if ({button0, busy0, done0, err0} !== 4'b1000)
         $display("FAIL reset_async_b0: outputs {button,busy,done,err}=%b, expected 1000", {button0, busy0, done0, err0}); else n_pass++;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_checks++; if ({button2, busy2, done2, err2, button0, busy0, done0, err0} !== 8'b1000_1000)
         $display("FAIL reset_release: outputs=%b, expected 10001000", {button2, busy2, done2, err2, button0, busy0, done0, err0}); else n_pass++;
   endtask

   task automatic test_short_press();
      int d;
      sel = 1'b0;
      build_expected(1, 2);
      issue(2'd1);
      capture(100);
      d = first_diff();
      n_checks++; if (d >= 0)
         $display("FAIL short_trace: first difference at cycle %0d, got %0d busy cycles, expected %0d", d, obs_btn.size(), exp_btn.size()); else n_pass++;
      n_checks++; if (obs_busy != 47)
         $display("FAIL short_busy_len: got %0d, expected 47", obs_busy); else n_pass++;
      n_checks++; if (!obs_done || obs_done_busy !== 1'b0 || obs_done_btn !== 1'b1)
         $display("FAIL short_done: done=%0d busy=%b button=%b, expected 1 0 1", obs_done, obs_done_busy, obs_done_btn); else n_pass++;
      @(negedge clk);
      n_checks++; if (o_done !== 1'b0)
         $display("FAIL short_done_width: done=%b one cycle later, expected 0", o_done); else n_pass++;
   endtask

   task automatic test_long_no_bounce();
      int d;
      sel = 1'b1;
      build_expected(2, 0);
      issue(2'd2);
      capture(300);
      d = first_diff();
      n_checks++; if (d >= 0)
         $display("FAIL long_nb_trace: first difference at cycle %0d, got %0d busy cycles, expected %0d", d, obs_btn.size(), exp_btn.size()); else n_pass++;
      n_checks++; if (!obs_done || obs_done_busy !== 1'b0)
         $display("FAIL long_nb_done: done=%0d busy=%b, expected 1 0", obs_done, obs_done_busy); else n_pass++;
      sel = 1'b0;
   endtask

   task automatic test_invalid_kind();
      logic [1:0] bad_kinds [2];
      bad_kinds[0] = 2'd3;
      bad_kinds[1] = 2'd0;
      sel = 1'b0;
      for (int i = 0; i < 2; i++) begin
         issue(bad_kinds[i]);
         @(negedge clk);
         n_checks++; if ({o_err, o_busy, o_button} !== 3'b101)
            $display("FAIL invalid_kind%0d: {err,busy,button}=%b, expected 101", bad_kinds[i], {o_err, o_busy, o_button}); else n_pass++;
         @(negedge clk);
         n_checks++; if ({o_err, o_busy, o_button} !== 3'b001)
            $display("FAIL invalid_kind%0d_after: {err,busy,button}=%b, expected 001", bad_kinds[i], {o_err, o_busy, o_button}); else n_pass++;
      end
   endtask

   task automatic test_abort();
      int bad;
      int d;
      sel = 1'b0;
      issue(2'd2);
      repeat (50) @(posedge clk);
      #1 abort_drv = 1'b1;
      @(posedge clk); #1 abort_drv = 1'b0;
      n_checks++; if ({o_button, o_busy, o_done} !== 3'b100)
         $display("FAIL abort_long: {button,busy,done}=%b, expected 100", {o_button, o_busy, o_done}); else n_pass++;
      bad = 0;
      repeat (250) begin
         @(negedge clk);
         if (o_done !== 1'b0 || o_busy !== 1'b0 || o_button !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0)
         $display("FAIL abort_long_quiet: %0d non-idle cycles after abort, expected 0", bad); else n_pass++;

      // Abort landing on the final gap cycle wins over completion.
      issue(2'd1);
      repeat (46) @(posedge clk);
      #1 abort_drv = 1'b1;
      @(posedge clk); #1 abort_drv = 1'b0;
      n_checks++; if ({o_button, o_busy, o_done} !== 3'b100)
         $display("FAIL abort_last_gap: {button,busy,done}=%b, expected 100", {o_button, o_busy, o_done}); else n_pass++;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (o_done !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0)
         $display("FAIL abort_last_gap_done: done seen %0d times, expected 0", bad); else n_pass++;

      // Abort together with start in IDLE still accepts the start.
      build_expected(1, 2);
      @(posedge clk); #1;
      start_drv = 1'b1; kind_drv = 2'd1; abort_drv = 1'b1;
      @(posedge clk); #1;
      start_drv = 1'b0; abort_drv = 1'b0;
      capture(100);
      d = first_diff();
      n_checks++; if (d >= 0 || !obs_done)
         $display("FAIL abort_start_idle: first difference at %0d, done=%0d, got %0d cycles, expected %0d", d, obs_done, obs_btn.size(), exp_btn.size()); else n_pass++;
   endtask

   task automatic test_async_reset();
      int bad;
      int d;
      sel = 1'b0;
      issue(2'd1);
      @(posedge clk); #1 start_drv = 1'b1; kind_drv = 2'd2;
      @(posedge clk); #1 start_drv = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++; if ({o_button, o_busy, o_done, o_err} !== 4'b1000)
         $display("FAIL reset_mid_hold: {button,busy,done,err}=%b before next edge, expected 1000", {o_button, o_busy, o_done, o_err}); else n_pass++;
      #1 reset = 1'b0;
      bad = 0;
      repeat (260) begin
         @(negedge clk);
         if (o_done !== 1'b0 || o_busy !== 1'b0 || o_button !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0)
         $display("FAIL reset_no_resume: %0d non-idle cycles after reset, expected 0", bad); else n_pass++;
      build_expected(1, 2);
      issue(2'd1);
      capture(100);
      d = first_diff();
      n_checks++; if (d >= 0 || !obs_done)
         $display("FAIL reset_then_press: first difference at %0d, done=%0d", d, obs_done); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int d;
      sel = 1'b0;
      build_expected(1, 2);
      @(posedge clk); #1 start_drv = 1'b1; kind_drv = 2'd1;
      @(posedge clk); #1;
      capture(100);
      d = first_diff();
      n_checks++; if (d >= 0 || !obs_done)
         $display("FAIL b2b_first: first difference at %0d, done=%0d", d, obs_done); else n_pass++;
      @(negedge clk);
      n_checks++; if ({o_button, o_busy, o_done} !== 3'b100)
         $display("FAIL b2b_idle_cycle: {button,busy,done}=%b, expected 100", {o_button, o_busy, o_done}); else n_pass++;
      capture(100);
      start_drv = 1'b0;
      d = first_diff();
      n_checks++; if (d >= 0 || !obs_done)
         $display("FAIL b2b_second: first difference at %0d, done=%0d, got %0d cycles", d, obs_done, obs_btn.size()); else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++; if (o_busy !== 1'b0)
         $display("FAIL b2b_stop: busy=%b after start released, expected 0", o_busy); else n_pass++;
   endtask

   task automatic test_random();
      int d;
      logic [1:0] k;
      for (int it = 0; it < 8; it++) begin
         sel = 1'($urandom_range(0, 1));
         k   = 2'($urandom_range(0, 3));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         issue(k);
         if (k == 2'd1 || k == 2'd2) begin
            build_expected(int'(k), sel ? 0 : 2);
            nz_on = 1'b1;
            capture(exp_btn.size() + 20);
            nz_on = 1'b0;
            d = first_diff();
            n_checks++; if (d >= 0 || !obs_done || obs_err)
               $display("FAIL rand%0d_press: sel=%b kind=%0d first diff %0d, done=%0d err_seen=%0d, got %0d cycles expected %0d",
                        it, sel, k, d, obs_done, obs_err, obs_btn.size(), exp_btn.size()); else n_pass++;
         end else begin
            @(negedge clk);
            n_checks++; if ({o_err, o_busy, o_button} !== 3'b101)
               $display("FAIL rand%0d_invalid: sel=%b kind=%0d {err,busy,button}=%b, expected 101", it, sel, k, {o_err, o_busy, o_button}); else n_pass++;
         end
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_no_bounce();
      test_invalid_kind();
      test_abort();
      test_async_reset();
      test_back_to_back();
      test_random();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/button_press_gen.md
BUTTON_PRESS_GEN -- requirements
Module: button_press_gen

Interface
REQ-001 Parameter MAX, default 50_000_000: base timing unit in clk cycles (one second at 50 MHz).
REQ-002 Parameter SHORT_CYC, default MAX/4: low-hold length of a short press.
REQ-003 Parameter LONG_CYC, default 2*MAX: low-hold length of a long press.
REQ-004 Parameter GAP_CYC, default MAX/10: released quiet time after each press.
REQ-005 Parameter BOUNCE_CYC, default 1000: length of each bounce segment.
REQ-006 Parameter BOUNCE_N, default 4, even, may be 0: number of bounce toggles per edge.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  request to emit one press; sampled only in IDLE.
REQ-010 kind  input  2  press type: 1 = short, 2 = long; 0 and 3 are invalid.
REQ-011 abort  input  1  cancels an emission in progress.
REQ-012 button  output  1  emulated active-low push-button line; 1 = released.
REQ-013 busy  output  1  high while an emission is in progress.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 err  output  1  one-cycle pulse when start is given with an invalid kind.

Function
REQ-016 All outputs SHALL be registered; states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-017 Cycle counter SHALL be 32 bits wide; all parameter-derived lengths SHALL fit in 32 bits.
REQ-018 IDLE with start=1 and kind in {1,2} at edge t SHALL latch kind, set busy=1, button=0, and enter BOUNCE_IN (HOLD if BOUNCE_N=0).
REQ-019 IDLE with start=1 and kind in {0,3} SHALL pulse err for one cycle and remain IDLE with button=1.
REQ-020 start while busy SHALL be ignored; the latched kind SHALL NOT change mid-emission.
REQ-021 BOUNCE_IN: button SHALL invert after every BOUNCE_CYC cycles, BOUNCE_N times; it ends at 0 and the block enters HOLD.
REQ-022 HOLD: button SHALL stay 0 for exactly SHORT_CYC (kind 1) or LONG_CYC (kind 2) cycles.
REQ-023 With BOUNCE_N=0, the total low time SHALL be exactly SHORT_CYC or LONG_CYC cycles.
REQ-024 Leaving HOLD SHALL set button=1 and enter BOUNCE_OUT (GAP if BOUNCE_N=0).
REQ-025 BOUNCE_OUT SHALL mirror BOUNCE_IN and end with button=1.
REQ-026 GAP: button SHALL stay 1 for GAP_CYC cycles.
REQ-027 On the edge that ends GAP: done=1 for one cycle, busy=0, state=IDLE.
REQ-028 A start in the cycle done is high SHALL be ignored; the earliest accepted start is on the following edge.
REQ-029 abort=1 in any non-IDLE state SHALL, on the next edge, set button=1, busy=0, and state=IDLE, with no done pulse.
REQ-030 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL accept start.
REQ-031 abort and the final GAP cycle together SHALL abort, with done remaining 0.

Reset
REQ-032 reset=1 SHALL immediately, without waiting for clk, force button=1, busy=0, done=0, err=0, counter=0, latched kind=0, state=IDLE.
REQ-033 Reset asserted mid-emission SHALL discard the emission, and no done SHALL follow; operation resumes on the first edge after reset deasserts.

Verification (MAX=100, SHORT_CYC=25, LONG_CYC=200, GAP_CYC=10, BOUNCE_CYC=3, BOUNCE_N=2)
REQ-034 start, kind=1 -> button sequence 0x3, 1x3, 0x25, 1x3, 0x3, 1x10, then done for 1 cycle; busy high for 47 cycles.
REQ-035 start, kind=2 with BOUNCE_N=0 -> button 0 for exactly 200 cycles, then 1 for 10 cycles, then done.
REQ-036 start, kind=3 -> err high for 1 cycle, busy stays 0, button stays 1.
REQ-037 abort 50 cycles into a long press -> button=1 and busy=0 on the next edge, and no done pulse.
REQ-038 async reset pulse between edges during HOLD -> button=1 before the next edge; a second start pulsed while busy was high is never emitted.
REQ-039 back-to-back: start held high continuously with kind=1 -> the second press begins exactly one cycle after done, and presses repeat.
